// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I MEM stage.
package rv32i_pkg;

  // funct3 encodings of load/store width and signedness
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Bus access sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Wide enough for ACK_TIMEOUT up to 255
  localparam int unsigned TMO_CNT_W = 8;

endpackage

// File: rtl/rv32i_mem_align.sv
// Combinational lane formatting for stores, extraction/extension for loads,
// and legality check of the requested access.
module rv32i_mem_align
  import rv32i_pkg::*;
(
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Store byte enables and lane-replicated write data; loads read the whole word
  always_comb begin
    be    = '1;
    wdata = rs2_data;
    if (!rd_en) begin
      case (op)
        MEM_B: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{rs2_data[7:0]}};
        end
        MEM_H: begin
          be    = 4'b0011 << {addr_lo[1], 1'b0};
          wdata = {2{rs2_data[15:0]}};
        end
        default: begin
          be    = '1;
          wdata = rs2_data;
        end
      endcase
    end
  end

  // Select the addressed byte/halfword of the read word and extend it
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      default: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_B:   load_data = {{24{sel_byte[7]}}, sel_byte};
      MEM_BU:  load_data = {24'b0, sel_byte};
      MEM_H:   load_data = {{16{sel_half[15]}}, sel_half};
      MEM_HU:  load_data = {16'b0, sel_half};
      default: load_data = rdata;
    endcase
  end

  // Flag conflicting enables, reserved encodings, unsigned stores and misalignment
  always_comb begin
    illegal = 1'b0;
    if (rd_en || wr_en) begin
      if (rd_en && wr_en)
        illegal = 1'b1;
      if (op == 3'b011 || op == 3'b110 || op == 3'b111)
        illegal = 1'b1;
      if (wr_en && (op == MEM_BU || op == MEM_HU))
        illegal = 1'b1;
      if ((op == MEM_H || op == MEM_HU) && addr_lo[0])
        illegal = 1'b1;
      if (op == MEM_W && addr_lo != 2'b00)
        illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_mem.sv
// MEM stage: issues single-outstanding data-memory accesses, stalls upstream
// while an access is in flight, and drives the MEM/WB register.
module rv32i_mem
  import rv32i_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned XLEN        = 32
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            EX_Mem_rd_en,
  input  logic            EX_Mem_wr_en,
  input  logic [2:0]      EX_Mem_op,
  input  logic            EX_MemToReg,
  input  logic            EX_RegFile_wr_en,
  input  logic [4:0]      EX_Rd_addr,
  input  logic [XLEN-1:0] EX_ALU_result,
  input  logic [XLEN-1:0] EX_Rs2_data,
  output logic            DMem_req,
  output logic            DMem_we,
  output logic [XLEN-1:0] DMem_addr,
  output logic [3:0]      DMem_be,
  output logic [XLEN-1:0] DMem_wdata,
  input  logic            DMem_ack,
  input  logic [XLEN-1:0] DMem_rdata,
  output logic            MEM_Stall,
  output logic            MEM_RegFile_wr_en,
  output logic            MEM_MemToReg,
  output logic [4:0]      MEM_Rd_addr,
  output logic [XLEN-1:0] MEM_ALU_result,
  output logic [XLEN-1:0] MEM_Load_data,
  output logic            MEM_Access_fault
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(ACK_TIMEOUT - 1);

  state_t                 state, state_next;
  logic [TMO_CNT_W-1:0]   tmo_cnt;
  logic                   mem_op;
  logic                   issue;
  logic                   ack_done;
  logic                   timeout;
  logic [3:0]             fmt_be;
  logic [XLEN-1:0]        fmt_wdata;
  logic [XLEN-1:0]        fmt_load;
  logic                   illegal;

  assign mem_op = EX_Mem_rd_en || EX_Mem_wr_en;

  rv32i_mem_align u_align (
    .rd_en     (EX_Mem_rd_en),
    .wr_en     (EX_Mem_wr_en),
    .op        (EX_Mem_op),
    .addr_lo   (EX_ALU_result[1:0]),
    .rs2_data  (EX_Rs2_data),
    .rdata     (DMem_rdata),
    .be        (fmt_be),
    .wdata     (fmt_wdata),
    .load_data (fmt_load),
    .illegal   (illegal)
  );

  // State register and WAIT-cycle counter (cleared whenever WAIT is left)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_next;
      tmo_cnt <= (state == WAIT && state_next == WAIT) ? tmo_cnt + 1'b1 : '0;
    end
  end

  // Next state, stall and the issue/complete/abort events
  always_comb begin
    state_next = state;
    MEM_Stall  = 1'b0;
    issue      = 1'b0;
    ack_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !illegal) begin
          MEM_Stall  = 1'b1;
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // an ack in the final WAIT cycle wins over the timeout
        if (DMem_ack) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          MEM_Stall  = 1'b1;
        end
      end
    endcase
  end

  // Bus request registers and MEM/WB register updates
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      DMem_req          <= 1'b0;
      DMem_we           <= 1'b0;
      DMem_addr         <= '0;
      DMem_be           <= '0;
      DMem_wdata        <= '0;
      MEM_RegFile_wr_en <= 1'b0;
      MEM_MemToReg      <= 1'b0;
      MEM_Rd_addr       <= '0;
      MEM_ALU_result    <= '0;
      MEM_Load_data     <= '0;
      MEM_Access_fault  <= 1'b0;
    end else begin
      MEM_Access_fault <= 1'b0;
      if (issue) begin
        DMem_req          <= 1'b1;
        DMem_we           <= EX_Mem_wr_en;
        DMem_addr         <= {EX_ALU_result[XLEN-1:2], 2'b00};
        DMem_be           <= fmt_be;
        DMem_wdata        <= fmt_wdata;
        MEM_RegFile_wr_en <= 1'b0;
      end else if (state == IDLE || ack_done || timeout) begin
        // EX is either advancing or was held for the access just finished
        MEM_MemToReg      <= EX_MemToReg;
        MEM_Rd_addr       <= EX_Rd_addr;
        MEM_ALU_result    <= EX_ALU_result;
        MEM_RegFile_wr_en <= EX_RegFile_wr_en && !(state == IDLE && illegal) && !timeout;
        MEM_Access_fault  <= (state == IDLE && illegal) || timeout;
        if (state == WAIT)
          DMem_req <= 1'b0;
        if (ack_done && !DMem_we)
          MEM_Load_data <= fmt_load;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem.sv
// Directed bench for the MEM stage with a per-cycle reference model.
module tb_rv32i_mem;

  localparam int TMO = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        EX_Mem_rd_en, EX_Mem_wr_en;
  logic [2:0]  EX_Mem_op;
  logic        EX_MemToReg, EX_RegFile_wr_en;
  logic [4:0]  EX_Rd_addr;
  logic [31:0] EX_ALU_result, EX_Rs2_data;
  logic        DMem_req, DMem_we;
  logic [31:0] DMem_addr, DMem_wdata, DMem_rdata;
  logic [3:0]  DMem_be;
  logic        DMem_ack;
  logic        MEM_Stall, MEM_RegFile_wr_en, MEM_MemToReg, MEM_Access_fault;
  logic [4:0]  MEM_Rd_addr;
  logic [31:0] MEM_ALU_result, MEM_Load_data;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  always #5 Clk = ~Clk;

  rv32i_mem #(.ACK_TIMEOUT(TMO), .XLEN(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_op(EX_Mem_op),
    .EX_MemToReg(EX_MemToReg), .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
    .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data),
    .DMem_req(DMem_req), .DMem_we(DMem_we), .DMem_addr(DMem_addr), .DMem_be(DMem_be),
    .DMem_wdata(DMem_wdata), .DMem_ack(DMem_ack), .DMem_rdata(DMem_rdata),
    .MEM_Stall(MEM_Stall), .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_MemToReg(MEM_MemToReg),
    .MEM_Rd_addr(MEM_Rd_addr), .MEM_ALU_result(MEM_ALU_result), .MEM_Load_data(MEM_Load_data),
    .MEM_Access_fault(MEM_Access_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit f_illegal(bit rd, bit wr, logic [2:0] op, logic [31:0] a);
    if (!(rd || wr)) return 0;
    if (rd && wr) return 1;
    if (op == 3 || op == 6 || op == 7) return 1;
    if (wr && (op == 4 || op == 5)) return 1;
    if ((op == 1 || op == 5) && a[0]) return 1;
    if (op == 2 && a[1:0] != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] f_be(bit rd, logic [2:0] op, logic [31:0] a);
    int unsigned k;
    if (rd) return 4'hF;
    k = a % 4;
    if (op == 0) return 4'(1 << k);
    if (op == 1) return (k >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(logic [2:0] op, logic [31:0] d);
    if (op == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(logic [2:0] op, logic [31:0] a, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 0;
  int          m_n = 0;
  logic        e_req = 0, e_we = 0, e_wr = 0, e_m2r = 0, e_fault = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_alu = 0, e_ld = 0;
  logic [3:0]  e_be = 0;
  logic [4:0]  e_rd = 0;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_busy <= 0; m_n <= 0;
      e_req <= 0; e_we <= 0; e_addr <= 0; e_be <= 0; e_wdata <= 0;
      e_wr <= 0; e_m2r <= 0; e_rd <= 0; e_alu <= 0; e_ld <= 0; e_fault <= 0;
    end else if (!m_busy) begin
      e_fault <= 0;
      if (!(EX_Mem_rd_en || EX_Mem_wr_en) ||
          f_illegal(EX_Mem_rd_en, EX_Mem_wr_en, EX_Mem_op, EX_ALU_result)) begin
        e_m2r <= EX_MemToReg; e_rd <= EX_Rd_addr; e_alu <= EX_ALU_result;
        if (EX_Mem_rd_en || EX_Mem_wr_en) begin
          e_wr <= 0; e_fault <= 1;
        end else begin
          e_wr <= EX_RegFile_wr_en;
        end
      end else begin
        m_busy <= 1; m_n <= 0;
        e_req <= 1; e_we <= EX_Mem_wr_en;
        e_addr <= EX_ALU_result & ~32'h3;
        e_be <= f_be(EX_Mem_rd_en, EX_Mem_op, EX_ALU_result);
        e_wdata <= f_wdata(EX_Mem_op, EX_Rs2_data);
        e_wr <= 0;
      end
    end else begin
      e_fault <= 0;
      if (DMem_ack || m_n + 1 == TMO) begin
        m_busy <= 0; e_req <= 0;
        e_m2r <= EX_MemToReg; e_rd <= EX_Rd_addr; e_alu <= EX_ALU_result;
        e_wr <= DMem_ack ? EX_RegFile_wr_en : 1'b0;
        e_fault <= !DMem_ack;
        if (DMem_ack && !e_we) e_ld <= f_load(EX_Mem_op, EX_ALU_result, DMem_rdata);
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clk) begin
    if (check_en) begin
      logic e_stall;
      if (m_busy) e_stall = !DMem_ack && (m_n + 1 != TMO);
      else e_stall = (EX_Mem_rd_en || EX_Mem_wr_en) &&
                     !f_illegal(EX_Mem_rd_en, EX_Mem_wr_en, EX_Mem_op, EX_ALU_result);
      chk("stall", 32'(MEM_Stall), 32'(e_stall));
      chk("req", 32'(DMem_req), 32'(e_req));
      if (e_req) begin
        chk("we", 32'(DMem_we), 32'(e_we));
        chk("addr", DMem_addr, e_addr);
        chk("be", 32'(DMem_be), 32'(e_be));
        chk("wdata", DMem_wdata, e_wdata);
      end
      chk("wb_en", 32'(MEM_RegFile_wr_en), 32'(e_wr));
      chk("m2r", 32'(MEM_MemToReg), 32'(e_m2r));
      chk("rd", 32'(MEM_Rd_addr), 32'(e_rd));
      chk("alu", MEM_ALU_result, e_alu);
      chk("ld", MEM_Load_data, e_ld);
      chk("fault", 32'(MEM_Access_fault), 32'(e_fault));
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  bit          s_taken;

  task automatic idle_inputs();
    EX_Mem_rd_en = 0; EX_Mem_wr_en = 0; EX_Mem_op = 0; EX_MemToReg = 0;
    EX_RegFile_wr_en = 0; EX_Rd_addr = 0; EX_ALU_result = 0; EX_Rs2_data = 0;
    DMem_ack = 0;
  endtask

  // Present one EX op and hold it while stalled; ack in WAIT cycle ack_at (0 = never)
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] rdata, input int ack_at,
                       input logic [4:0] rda, input bit rwe, input bit m2r,
                       output int n_stall, output int n_req);
    bit stalled, done;
    EX_Mem_rd_en = rd; EX_Mem_wr_en = wr; EX_Mem_op = op; EX_ALU_result = alu;
    EX_Rs2_data = rs2; EX_Rd_addr = rda; EX_RegFile_wr_en = rwe; EX_MemToReg = m2r;
    DMem_rdata = rdata;
    n_stall = 0; n_req = 0; s_taken = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      DMem_ack = (c >= 1 && c == ack_at);
      @(negedge Clk);
      stalled = MEM_Stall;
      if (MEM_Stall) n_stall++;
      if (DMem_req) begin
        n_req++;
        if (!s_taken) begin
          s_taken = 1; s_we = DMem_we; s_addr = DMem_addr; s_be = DMem_be; s_wdata = DMem_wdata;
        end
      end
      @(posedge Clk); #1;
      DMem_ack = 0;
      if (!stalled) begin done = 1; break; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL stall_bound: stall still high after 40 cycles, required low");
    end
  endtask

  initial begin
    int ns, nr;
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int ns, nr;
    Reset_n = 0;
    DMem_rdata = 0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_req", 32'(DMem_req), 0);
    chk("rst_alu", MEM_ALU_result, 0);
    check_en = 1;
    Reset_n = 1;

    // 1: SW with ack in 3rd WAIT cycle
    do_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 3, 5'd0, 0, 0, ns, nr);
    chk("sw_addr", s_addr, 32'h100);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_wdata", s_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(s_we), 1);
    chk("sw_stall_cycles", 32'(ns), 3);
    chk("sw_wb_en", 32'(MEM_RegFile_wr_en), 0);
    idle_inputs();

    // 2: LB / LBU at 0x103
    do_op(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 1, 5'd7, 1, 1, ns, nr);
    chk("lb_data", MEM_Load_data, 32'hFFFFFF80);
    chk("lb_stall_cycles", 32'(ns), 1);
    chk("lb_wb_en", 32'(MEM_RegFile_wr_en), 1);
    chk("lb_be", 32'(s_be), 32'hF);
    do_op(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1, 5'd7, 1, 1, ns, nr);
    chk("lbu_data", MEM_Load_data, 32'h00000080);
    chk("lbu_stall_cycles", 32'(ns), 1);
    do_op(1, 0, 3'b001, 32'h102, 0, 32'h80112233, 2, 5'd8, 1, 1, ns, nr);
    chk("lh_data", MEM_Load_data, 32'hFFFF8011);
    do_op(1, 0, 3'b101, 32'h100, 0, 32'h80112233, 1, 5'd8, 1, 1, ns, nr);
    chk("lhu_data", MEM_Load_data, 32'h00002233);
    idle_inputs();
    @(posedge Clk); #1;
    chk("ld_hold", MEM_Load_data, 32'h00002233);

    // 3: SH at 0x102, SB at 0x101
    do_op(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 1, 5'd0, 0, 0, ns, nr);
    chk("sh_addr", s_addr, 32'h100);
    chk("sh_be", 32'(s_be), 32'hC);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    do_op(0, 1, 3'b000, 32'h101, 32'h123456A5, 0, 2, 5'd0, 0, 0, ns, nr);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_wdata", s_wdata, 32'hA5A5A5A5);

    // 4: illegal accesses
    do_op(1, 0, 3'b010, 32'h102, 0, 0, 1, 5'd9, 1, 1, ns, nr);
    chk("lw_mis_fault", 32'(MEM_Access_fault), 1);
    chk("lw_mis_wb_en", 32'(MEM_RegFile_wr_en), 0);
    chk("lw_mis_req", 32'(nr), 0);
    chk("lw_mis_stall", 32'(ns), 0);
    do_op(1, 1, 3'b010, 32'h100, 0, 0, 1, 5'd9, 1, 0, ns, nr);
    chk("rdwr_fault", 32'(MEM_Access_fault), 1);
    chk("rdwr_req", 32'(nr), 0);
    idle_inputs();
    @(posedge Clk); #1;
    chk("fault_pulse_end", 32'(MEM_Access_fault), 0);

    // 5: LW timeout then ADD pass-through
    do_op(1, 0, 3'b010, 32'h200, 0, 0, 0, 5'd3, 1, 1, ns, nr);
    chk("tmo_req_cycles", 32'(nr), TMO);
    chk("tmo_fault", 32'(MEM_Access_fault), 1);
    chk("tmo_wb_en", 32'(MEM_RegFile_wr_en), 0);
    do_op(0, 0, 3'b000, 32'h7, 0, 0, 0, 5'd5, 1, 0, ns, nr);
    chk("add_alu", MEM_ALU_result, 32'h7);
    chk("add_rd", 32'(MEM_Rd_addr), 5);
    chk("add_wb_en", 32'(MEM_RegFile_wr_en), 1);
    chk("add_fault", 32'(MEM_Access_fault), 0);
    chk("add_ld_hold", MEM_Load_data, 32'h00002233);

    // 6: reset during WAIT, late ack ignored
    EX_Mem_rd_en = 1; EX_Mem_op = 3'b010; EX_ALU_result = 32'h300;
    EX_RegFile_wr_en = 1; EX_Rd_addr = 5'd4; EX_MemToReg = 1;
    @(posedge Clk); #1;
    chk("rw_req_up", 32'(DMem_req), 1);
    Reset_n = 0;
    @(posedge Clk); #1;
    chk("rw_req", 32'(DMem_req), 0);
    chk("rw_ld", MEM_Load_data, 0);
    chk("rw_alu", MEM_ALU_result, 0);
    Reset_n = 1;
    idle_inputs();
    DMem_ack = 1; DMem_rdata = 32'hFFFFFFFF;
    @(posedge Clk); #1;
    DMem_ack = 0;
    chk("late_ack_wb", 32'(MEM_RegFile_wr_en), 0);
    chk("late_ack_ld", MEM_Load_data, 0);
    @(posedge Clk); #1;

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
